spi_output_mux: RTL and testbench
=================================

# spi_output_mux

Parametrised SPI-slave-driven output multiplexer, second generation of the board's SPI output block. Receives framed SPI mode-0 transfers from the host MCU, buffers them in a shadow register bank of `CHANNELS` bytes, and commits them atomically to the output bus and differential-driver enables when chip select rises. Adds readback over MISO, an addressed command byte and frame-error detection. Sits between the MCU SPI port and the 3V3→5V translator and differential drivers.

## Interface
- `CHANNELS`, 4, number of 8-bit output channels; legal range 1–8.
- `SYNC_STAGES`, 2, synchroniser depth for the SPI inputs; legal range ≥2.
- `clk  in  1  master clock, 50 MHz`
- `reset  in  1  synchronous, active-low reset`
- `spi_nCS  in  1  SPI chip select, active low`
- `spi_sck  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0)`
- `spi_mosi  in  1  SPI data in, MSB first`
- `spi_miso  out  1  SPI data out; high-Z whenever synchronised nCS is high or reset is asserted`
- `out  out  8*CHANNELS  committed output bus; channel i is bits [8i+7:8i]`
- `out_en  out  CHANNELS  differential-driver enables`
- `buffer_oe  out  1  translator output enable`
- `status  out  3  LEDs: [0] reset active, [1] frame in progress, [2] sticky frame error`

## Operation
- `spi_sck`, `spi_nCS` and `spi_mosi` each pass through `SYNC_STAGES` flops. SCK rise and fall and nCS fall and rise are detected on the synchronised signals.
- States:
  - WAIT_CS: entered from reset. Moves to IDLE once synchronised nCS is high.
  - IDLE: on nCS fall, go to CMD. Clear bit counter and shadow-valid mask.
  - CMD: shift 8 bits in on SCK rise.
    - bit7 = target (0 data bank, 1 enable register).
    - bits[6:0] = start index.
    - After the 8th bit go to DATA.
  - DATA: each completed byte is written to the shadow at the current index, then the index increments.
    - Index ≥ CHANNELS: the byte is discarded and an overflow flag is set.
    - For the enable target, only index 0 is legal, and only bits [CHANNELS-1:0] are used.
  - COMMIT: entered on nCS rise from CMD or DATA. Lasts one cycle, then goes to IDLE.
- Commit rule: the commit happens only if all of the following hold; the frame then updates `out`/`out_en` bytes whose shadow-valid bit is set, and other bytes keep their value:
  - at least one data byte was written;
  - the bit counter is 0 (no partial byte);
  - there was no overflow.
- If the commit rule fails: no output change, and `status[2]` is set. `status[2]` clears on the next successful commit.
- MISO:
  - Updated on SCK fall, and preloaded with MSB on entry to CMD.
  - During the CMD byte it shifts constant ID 8'hA5.
  - During each data byte it shifts the currently committed value at the current index, or 8'h00 if the index is out of range.
- `buffer_oe` = 1 in every cycle with reset deasserted.
- Reset (any state, including mid-frame):
  - `out`, `out_en`, `buffer_oe`, `status[2:1]` and shadow go to 0.
  - `status[0]`=1 and `spi_miso`=Z.
  - State goes to WAIT_CS, so a frame already in progress is ignored until nCS is seen high.

## Timing
- Pin edge to internal detect: `SYNC_STAGES`+1 clk cycles.
- SCK high and low phases must each be ≥ `SYNC_STAGES`+2 clk cycles. With the defaults this limits SCK to ≤6.25 MHz.
- nCS rise at pin to `out` update: `SYNC_STAGES`+2 cycles.
- MISO valid `SYNC_STAGES`+2 cycles after SCK fall at pin. The host must sample on the next SCK rise.
- nCS rise and SCK edge detected in the same cycle: the nCS rise wins, and the SCK edge is ignored.
- `status[1]`=1 in CMD and DATA only.

## Structure
- Package `spi_mux_pkg` holds:
  - the state enum (WAIT_CS, IDLE, CMD, DATA, COMMIT);
  - the command field positions (TARGET_BIT=7, INDEX_MSB=6);
  - ID byte 8'hA5;
  - the parameter range limits.
- Sub-module `spi_sync_edge`: an N-stage synchroniser plus rise/fall pulse outputs. It is instantiated for SCK and nCS; MOSI uses the synchroniser path only.

## Test plan
- Write cmd 8'h00 then data 8'h11,22,33,44 (CHANNELS=4) → `out`=32'h44332211 exactly `SYNC_STAGES`+2 cycles after nCS rise, and `status[2]`=0.
- Write cmd 8'h02 then 8'hAA → only channel 2 becomes 8'hAA, and channels 0, 1 and 3 are unchanged.
- Write cmd 8'h80 then 8'h05 → `out_en`=4'b0101, and `out` is unchanged.
- Raise nCS after cmd plus 5 data bits → no output change and `status[2]`=1. A following valid frame clears `status[2]`.
- Write cmd 8'h03 then 2 bytes (overflow) → no commit and `status[2]`=1. MISO returns A5 for the cmd byte, then `out[31:24]`, then 00.
- Assert reset mid-DATA, release while nCS is still low, keep clocking → outputs stay 0 and no commit occurs. The next full frame after an nCS high is accepted.

Source files
------------

// File: rtl/spi_mux_pkg.sv
// Shared types and constants for the SPI output multiplexer: FSM states,
// command-byte field positions, readback ID and parameter limits.
package spi_mux_pkg;

  typedef enum logic [2:0] {
    WAIT_CS,
    IDLE,
    CMD,
    DATA,
    COMMIT
  } state_t;

  localparam int unsigned TARGET_BIT      = 7;
  localparam int unsigned INDEX_MSB       = 6;
  localparam logic [7:0]  ID_BYTE         = 8'hA5;

  localparam int unsigned CHANNELS_MIN    = 1;
  localparam int unsigned CHANNELS_MAX    = 8;
  localparam int unsigned SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from the synchronised level.
module spi_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Unreset on purpose: the chain keeps tracking the pin through reset so
  // that no spurious edge appears when reset releases.
  always_ff @(posedge i_clk) begin
    r_sync <= {r_sync[STAGES-2:0], i_d};
    r_prev <= r_sync[STAGES-1];
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise =  r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] &  r_prev;

endmodule

// File: rtl/spi_output_mux.sv
// SPI mode-0 slave that loads a shadow bank of output bytes and enables,
// committing them atomically on chip-select rise; ID/readback on MISO.
module spi_output_mux
  import spi_mux_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_nCS,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic [8*CHANNELS-1:0] out,
  output logic [CHANNELS-1:0]   out_en,
  output logic                  buffer_oe,
  output logic [2:0]            status
);

  logic w_sck_q, w_sck_rise, w_sck_fall;
  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic w_mosi_q, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .i_clk(clk), .i_d(spi_sck), .o_q(w_sck_q), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .i_clk(clk), .i_d(spi_nCS), .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .i_clk(clk), .i_d(spi_mosi), .o_q(w_mosi_q), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );
  assign w_unused = &{1'b0, w_sck_q, w_mosi_rise, w_mosi_fall};

  state_t                r_state, w_next;
  logic [2:0]            r_bitcnt;
  logic [6:0]            r_shift;
  logic                  r_target;
  logic [6:0]            r_index;
  logic [8*CHANNELS-1:0] r_shadow;
  logic [CHANNELS-1:0]   r_shadow_en;
  logic [CHANNELS-1:0]   r_valid;
  logic                  r_en_valid;
  logic                  r_wrote;
  logic                  r_ovf;
  logic [7:0]            r_miso_sr;
  logic [8*CHANNELS-1:0] r_out;
  logic [CHANNELS-1:0]   r_out_en;
  logic                  r_err;

  logic [7:0] w_byte;
  logic [7:0] w_rb;
  logic       w_in_range;

  assign w_byte     = {r_shift, w_mosi_q};
  assign w_in_range = (r_index < 7'(CHANNELS));

  always_ff @(posedge clk) begin
    if (!reset) r_state <= WAIT_CS;
    else        r_state <= w_next;
  end

  // nCS rise takes priority over any SCK edge seen in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_CS: if (w_cs_q)    w_next = IDLE;
      IDLE:    if (w_cs_fall) w_next = CMD;
      CMD: begin
        if (w_cs_rise)                           w_next = COMMIT;
        else if (w_sck_rise && r_bitcnt == 3'd7) w_next = DATA;
      end
      DATA:    if (w_cs_rise) w_next = COMMIT;
      COMMIT:  w_next = IDLE;
      default: w_next = WAIT_CS;
    endcase
  end

  // Readback source for the data byte at the current index.
  always_comb begin
    w_rb = '0;
    if (r_target) begin
      if (r_index == '0) w_rb[CHANNELS-1:0] = r_out_en;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++)
        if (r_index == 7'(i)) w_rb = r_out[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_target    <= 1'b0;
      r_index     <= '0;
      r_shadow    <= '0;
      r_shadow_en <= '0;
      r_valid     <= '0;
      r_en_valid  <= 1'b0;
      r_wrote     <= 1'b0;
      r_ovf       <= 1'b0;
      r_miso_sr   <= '0;
      r_out       <= '0;
      r_out_en    <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_cs_fall) begin
          r_bitcnt   <= '0;
          r_valid    <= '0;
          r_en_valid <= 1'b0;
          r_wrote    <= 1'b0;
          r_ovf      <= 1'b0;
          r_miso_sr  <= ID_BYTE;
        end
        CMD, DATA: if (!w_cs_rise) begin
          if (w_sck_rise) begin
            r_shift  <= w_byte[6:0];
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              if (r_state == CMD) begin
                r_target <= w_byte[TARGET_BIT];
                r_index  <= w_byte[INDEX_MSB:0];
              end else begin
                if (r_target) begin
                  if (r_index == '0) begin
                    r_shadow_en <= w_byte[CHANNELS-1:0];
                    r_en_valid  <= 1'b1;
                    r_wrote     <= 1'b1;
                  end else begin
                    r_ovf <= 1'b1;
                  end
                end else if (w_in_range) begin
                  for (int unsigned i = 0; i < CHANNELS; i++)
                    if (r_index == 7'(i)) begin
                      r_shadow[8*i +: 8] <= w_byte;
                      r_valid[i]         <= 1'b1;
                    end
                  r_wrote <= 1'b1;
                end else begin
                  r_ovf <= 1'b1;
                end
                r_index <= r_index + 7'd1;
              end
            end
          end
          // First fall after a byte boundary in DATA loads the next readback byte.
          if (w_sck_fall)
            r_miso_sr <= (r_state == DATA && r_bitcnt == 3'd0) ? w_rb : {r_miso_sr[6:0], 1'b0};
        end
        COMMIT: begin
          if (r_wrote && r_bitcnt == 3'd0 && !r_ovf) begin
            for (int unsigned i = 0; i < CHANNELS; i++)
              if (r_valid[i]) r_out[8*i +: 8] <= r_shadow[8*i +: 8];
            if (r_en_valid) r_out_en <= r_shadow_en;
            r_err <= 1'b0;
          end else begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign spi_miso  = (!reset || w_cs_q) ? 1'bz : r_miso_sr[7];
  assign out       = r_out;
  assign out_en    = r_out_en;
  assign buffer_oe = reset;
  assign status    = {r_err, (r_state == CMD || r_state == DATA), ~reset};

endmodule

// File: tb/tb_spi_output_mux.sv
// Directed bench for spi_output_mux: a table of SPI frames with expected
// outputs, plus reset and commit-latency sequences.
module tb_spi_output_mux;

  localparam int unsigned CH   = 4;
  localparam int unsigned SYNC = 2;
  localparam int          HALF = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          spi_nCS, spi_sck, spi_mosi;
  wire           spi_miso;
  logic [8*CH-1:0] out;
  logic [CH-1:0]   out_en;
  logic            buffer_oe;
  logic [2:0]      status;

  spi_output_mux #(.CHANNELS(CH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .spi_nCS(spi_nCS), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .out(out), .out_en(out_en),
    .buffer_oe(buffer_oe), .status(status)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_out = '0;
  logic [3:0]  model_en  = '0;
  logic [7:0]  got [0:5];
  logic [7:0]  dummy;

  typedef struct {
    logic [7:0]  cmd;
    int          nbytes;
    logic [31:0] data;
    int          extra;
    logic [31:0] exp_out;
    logic [3:0]  exp_en;
    logic        exp_err;
    logic [1:0]  chk_rb;
    logic [7:0]  rb0;
    logic [7:0]  rb1;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int nbits, output logic [7:0] rb);
    rb = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[7-i];
      repeat (HALF) tick();
      rb[7-i] = spi_miso;
      spi_sck = 1'b1;
      repeat (HALF) tick();
      spi_sck = 1'b0;
    end
  endtask

  task automatic do_frame(input logic [7:0] cmd, input int nbytes, input logic [31:0] data,
                          input int extra, input logic [31:0] exp_out,
                          input logic [3:0] exp_en, input logic exp_err);
    spi_nCS = 1'b0;
    repeat (HALF) tick();
    send_byte(cmd, 8, got[0]);
    for (int k = 0; k < nbytes; k++) send_byte(data[8*k +: 8], 8, got[k+1]);
    if (extra > 0) send_byte(8'hFF, extra, dummy);
    repeat (HALF) tick();
    chk("busy_in_frame", 32'(status[1]), 32'd1);
    spi_nCS = 1'b1;
    repeat (SYNC + 1) tick();
    chk("out_hold_before_commit", out, model_out);
    tick();
    chk("out_after_commit", out, exp_out);
    chk("out_en_after_commit", 32'(out_en), 32'(exp_en));
    chk("frame_error", 32'(status[2]), 32'(exp_err));
    chk("busy_after_commit", 32'(status[1]), 32'd0);
    model_out = exp_out;
    model_en  = exp_en;
    repeat (HALF) tick();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          cmd    n  data          ex exp_out       en    err chk   rb0    rb1
    vecs[0]  = '{8'h00, 4, 32'h44332211, 0, 32'h44332211, 4'h0, 0, 2'b01, 8'h00, 8'h00};
    vecs[1]  = '{8'h02, 1, 32'h000000AA, 0, 32'h44AA2211, 4'h0, 0, 2'b01, 8'h33, 8'h00};
    vecs[2]  = '{8'h80, 1, 32'h00000005, 0, 32'h44AA2211, 4'h5, 0, 2'b00, 8'h00, 8'h00};
    vecs[3]  = '{8'h00, 0, 32'h00000000, 5, 32'h44AA2211, 4'h5, 1, 2'b00, 8'h00, 8'h00};
    vecs[4]  = '{8'h00, 1, 32'h0000005A, 0, 32'h44AA225A, 4'h5, 0, 2'b01, 8'h11, 8'h00};
    vecs[5]  = '{8'h03, 2, 32'h00008877, 0, 32'h44AA225A, 4'h5, 1, 2'b11, 8'h44, 8'h00};
    vecs[6]  = '{8'h01, 2, 32'h00006655, 0, 32'h4466555A, 4'h5, 0, 2'b11, 8'h22, 8'hAA};
    vecs[7]  = '{8'h00, 1, 32'h00000077, 3, 32'h4466555A, 4'h5, 1, 2'b01, 8'h5A, 8'h00};
    vecs[8]  = '{8'h80, 1, 32'h000000FF, 0, 32'h4466555A, 4'hF, 0, 2'b00, 8'h00, 8'h00};
    vecs[9]  = '{8'h81, 1, 32'h0000000F, 0, 32'h4466555A, 4'hF, 1, 2'b00, 8'h00, 8'h00};
    vecs[10] = '{8'h00, 1, 32'h00000001, 0, 32'h44665501, 4'hF, 0, 2'b01, 8'h5A, 8'h00};
    vecs[11] = '{8'h01, 0, 32'h00000000, 0, 32'h44665501, 4'hF, 1, 2'b00, 8'h00, 8'h00};

    reset = 1'b0; spi_nCS = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    repeat (5) tick();
    chk("rst_out", out, 32'h0);
    chk("rst_out_en", 32'(out_en), 32'h0);
    chk("rst_buffer_oe", 32'(buffer_oe), 32'd0);
    chk("rst_status", 32'(status), 32'b001);
    chk("rst_miso_z", 32'(spi_miso === 1'bz), 32'd1);
    reset = 1'b1;
    repeat (SYNC + 4) tick();
    chk("run_buffer_oe", 32'(buffer_oe), 32'd1);
    chk("run_status", 32'(status), 32'b000);
    chk("idle_miso_z", 32'(spi_miso === 1'bz), 32'd1);

    for (int v = 0; v < 12; v++) begin
      do_frame(vecs[v].cmd, vecs[v].nbytes, vecs[v].data, vecs[v].extra,
               vecs[v].exp_out, vecs[v].exp_en, vecs[v].exp_err);
      chk($sformatf("miso_id_v%0d", v), 32'(got[0]), 32'hA5);
      if (vecs[v].chk_rb[0]) chk($sformatf("miso_rb0_v%0d", v), 32'(got[1]), 32'(vecs[v].rb0));
      if (vecs[v].chk_rb[1]) chk($sformatf("miso_rb1_v%0d", v), 32'(got[2]), 32'(vecs[v].rb1));
    end

    // Reset in the middle of a data byte, released with nCS still low.
    spi_nCS = 1'b0;
    repeat (HALF) tick();
    send_byte(8'h00, 8, dummy);
    send_byte(8'h12, 8, dummy);
    send_byte(8'h34, 3, dummy);
    reset = 1'b0;
    repeat (3) tick();
    chk("midrst_out", out, 32'h0);
    chk("midrst_out_en", 32'(out_en), 32'h0);
    chk("midrst_status", 32'(status), 32'b001);
    chk("midrst_miso_z", 32'(spi_miso === 1'bz), 32'd1);
    reset = 1'b1;
    send_byte(8'hFF, 5, dummy);
    send_byte(8'h56, 8, dummy);
    repeat (HALF) tick();
    chk("midrst_not_busy", 32'(status[1]), 32'd0);
    spi_nCS = 1'b1;
    repeat (SYNC + 3) tick();
    chk("midrst_no_commit_out", out, 32'h0);
    chk("midrst_no_commit_en", 32'(out_en), 32'h0);
    chk("midrst_status_clean", 32'(status), 32'b000);
    model_out = '0;
    model_en  = '0;
    repeat (HALF) tick();

    do_frame(8'h00, 2, 32'h0000BC9A, 0, 32'h0000BC9A, 4'h0, 1'b0);
    chk("post_rst_miso_id", 32'(got[0]), 32'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
